me_result_collector: RTL

ME_RESULT_COLLECTOR -- requirements
Module: me_result_collector

---
 rtl/me_result_collector.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/me_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : me_result_collector
// Description : Sequences motion-estimator searches for one frame and queues
//               each {BestDist, motionX, motionY, block} result in a FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module me_result_collector #(
    parameter int NUM_BLOCKS = 16,
    parameter int DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    output logic       start,
    input  logic       completed,
    input  logic [7:0] BestDist,
    input  logic [3:0] motionX,
    input  logic [3:0] motionY,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_dist,
    output logic [3:0] out_mx,
    output logic [3:0] out_my,
    output logic [7:0] out_block,
    output logic       frame_done,
    output logic       overflow
);

    localparam int             c_ptr_w    = $clog2(DEPTH);
    localparam int             c_cnt_w    = c_ptr_w + 1;
    localparam logic [7:0]     c_last_blk = 8'(NUM_BLOCKS - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        STALL  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q, start_d;
    logic                 comp_prev_q;
    logic [7:0]           block_q, block_d;
    logic                 gap_q, gap_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overflow_q, overflow_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [23:0]          mem_q [DEPTH];
    logic [23:0]          mem_d [DEPTH];
    logic [23:0]          head_q, head_d;

    logic                 w_capture;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic [23:0]          w_entry;

    assign w_entry = {BestDist, motionX, motionY, block_q};

    always_comb begin
        state_d      = state_q;
        block_d      = block_q;
        gap_d        = gap_q;
        frame_done_d = 1'b0;
        w_capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = LAUNCH;
                    block_d = 8'd0;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                // Only a fresh rising edge of completed counts as a result.
                if (completed && !comp_prev_q) begin
                    w_capture = 1'b1;
                    if (block_q == c_last_blk) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        block_d = block_q + 8'd1;
                        gap_d   = 1'b0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q) begin
                    state_d = (count_q < c_full) ? LAUNCH : STALL;
                end else begin
                    gap_d = 1'b1;
                end
            end
            STALL: begin
                if (count_q < c_full) begin
                    state_d = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == LAUNCH) || (state_d == WAIT);
    end

    always_comb begin
        w_pop      = (count_q != '0) && out_ready;
        w_full     = (count_q == c_full);
        w_push     = w_capture && (!w_full || w_pop);
        overflow_d = overflow_q || (w_capture && w_full && !w_pop);
        wr_ptr_d   = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        count_d    = count_q + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
        mem_d      = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = w_entry;
        end
        // Head register holds its last value once the FIFO drains.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (w_push && (rd_ptr_d == wr_ptr_q)) ? w_entry : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            comp_prev_q  <= 1'b0;
            block_q      <= 8'd0;
            gap_q        <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_q        <= '{default: '0};
            head_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            comp_prev_q  <= completed;
            block_q      <= block_d;
            gap_q        <= gap_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
            head_q       <= head_d;
        end
    end

    assign start      = start_q;
    assign out_valid  = (count_q != '0);
    assign out_dist   = head_q[23:16];
    assign out_mx     = head_q[15:12];
    assign out_my     = head_q[11:8];
    assign out_block  = head_q[7:0];
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire
